// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the DSP16 fetch/decode slice: T-field opcodes,
// sequencer states and the instruction classes produced by the classifier.
package jtdsp16_pkg;

    localparam logic [4:0] T_GOTO_JA0 = 5'b00000;
    localparam logic [4:0] T_GOTO_JA1 = 5'b00001;
    localparam logic [4:0] T_CALL_JA0 = 5'b10000;
    localparam logic [4:0] T_CALL_JA1 = 5'b10001;
    localparam logic [4:0] T_GOTO_B   = 5'b11000;
    localparam logic [4:0] T_RIMM     = 5'b01010;
    localparam logic [4:0] T_RRAM     = 5'b00111;
    localparam logic [4:0] T_DO       = 5'b01110;

    localparam logic [15:0] ICALL_WORD_DEFAULT = 16'hD00E;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE    = 3'd0,
        CLS_GOTO_JA = 3'd1,
        CLS_CALL_JA = 3'd2,
        CLS_GOTO_B  = 3'd3,
        CLS_ICALL   = 3'd4,
        CLS_RIMM    = 3'd5,
        CLS_RRAM    = 3'd6,
        CLS_DO      = 3'd7
    } inst_class_t;

    // Classes whose following fetched word must be thrown away.
    function automatic logic cls_squashes(input inst_class_t c);
        return (c == CLS_GOTO_JA) || (c == CLS_CALL_JA) || (c == CLS_GOTO_B) ||
               (c == CLS_ICALL)   || (c == CLS_RIMM);
    endfunction

endpackage

// File: rtl/jtdsp16_dec_ctl.sv
// Combinational classifier: maps the instruction register onto the
// program-control class that the fetch sequencer acts on.
module jtdsp16_dec_ctl
    import jtdsp16_pkg::*;
#(
    parameter logic [15:0] ICALL_WORD = ICALL_WORD_DEFAULT
) (
    input  logic [15:0] ir,
    output inst_class_t cls
);

    logic [4:0] t_field;

    assign t_field = ir[15:11];

    // icall is an exact word match, so it is checked ahead of the T-field table
    always_comb begin
        cls = CLS_NONE;
        if (ir == ICALL_WORD) begin
            cls = CLS_ICALL;
        end else begin
            case (t_field)
                T_GOTO_JA0, T_GOTO_JA1: cls = CLS_GOTO_JA;
                T_CALL_JA0, T_CALL_JA1: cls = CLS_CALL_JA;
                T_GOTO_B:               cls = CLS_GOTO_B;
                T_RIMM:                 cls = CLS_RIMM;
                T_RRAM:                 cls = CLS_RRAM;
                T_DO:                   cls = CLS_DO;
                default:                cls = CLS_NONE;
            endcase
        end
    end

endmodule

// File: rtl/jtdsp16_fetch_dec.sv
// Fetch/decode stage feeding the XAAU: holds the IR, sequences branches,
// immediate and RAM loads, and flags cycles where an interrupt must wait.
module jtdsp16_fetch_dec
    import jtdsp16_pkg::*;
#(
    parameter logic [15:0] ICALL_WORD = ICALL_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [15:0] rom_dout,
    input  logic        iack,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        goto_ja,
    output logic        goto_b,
    output logic        call_ja,
    output logic        icall,
    output logic        post_inc,
    output logic        pc_halt,
    output logic        ram_load,
    output logic        imm_load,
    output logic        do_start,
    output logic [10:0] do_data,
    output logic [2:0]  r_field,
    output logic [11:0] i_field,
    output logic        no_int
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        primed_q, primed_d;
    inst_class_t cls;
    logic        take_int;
    logic        exec;

    jtdsp16_dec_ctl #(
        .ICALL_WORD (ICALL_WORD)
    ) u_dec_ctl (
        .ir  (ir_q),
        .cls (cls)
    );

    assign take_int = cen & iack;
    assign exec     = ~rst & ~take_int & ir_valid_q & (state_q == ST_RUN);

    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign do_data  = ir_q[10:0];
    assign r_field  = ir_q[6:4];
    assign i_field  = ir_q[11:0];
    assign no_int   = rst | (state_q != ST_RUN) | ~ir_valid_q | (cls != CLS_NONE);

    // Strobes decoded from the IR, suppressed in reset, on interrupt entry and outside RUN
    always_comb begin
        goto_ja  = 1'b0;
        goto_b   = 1'b0;
        call_ja  = 1'b0;
        icall    = 1'b0;
        pc_halt  = 1'b0;
        ram_load = 1'b0;
        imm_load = 1'b0;
        do_start = 1'b0;
        if (exec) begin
            case (cls)
                CLS_GOTO_JA: goto_ja  = 1'b1;
                CLS_CALL_JA: call_ja  = 1'b1;
                CLS_GOTO_B:  goto_b   = 1'b1;
                CLS_ICALL:   icall    = 1'b1;
                CLS_RIMM:    imm_load = 1'b1;
                CLS_RRAM:    pc_halt  = 1'b1;
                CLS_DO:      do_start = 1'b1;
                default:     ;
            endcase
        end
        if (~rst && ~take_int && (state_q == ST_WAIT)) begin
            ram_load = 1'b1;
        end
        post_inc = ram_load & ir_q[3];
    end

    // Next IR/state: interrupt entry overrides every sequence; the IR only
    // holds while a RAM load waits for its data cycle
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        primed_d   = primed_q;
        if (cen) begin
            primed_d = 1'b1;
            ir_d     = rom_dout;
            if (iack) begin
                state_d    = ST_SQUASH;
                ir_valid_d = 1'b0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        ir_valid_d = primed_q;
                        if (exec && cls_squashes(cls)) begin
                            state_d    = ST_SQUASH;
                            ir_valid_d = 1'b0;
                        end else if (exec && (cls == CLS_RRAM)) begin
                            state_d = ST_WAIT;
                            ir_d    = ir_q;
                        end
                    end
                    ST_WAIT: begin
                        state_d    = ST_RUN;
                        ir_valid_d = 1'b1;
                    end
                    ST_SQUASH: begin
                        state_d    = ST_RUN;
                        ir_valid_d = 1'b1;
                    end
                    default: begin
                        state_d    = ST_RUN;
                        ir_valid_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // State registers with synchronous reset taking priority over cen
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            ir_q       <= 16'h0000;
            ir_valid_q <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            primed_q   <= primed_d;
        end
    end

endmodule
